// File: rtl/tank_pkg.sv
// Shared game-side definitions: map geometry, map store latency and requester IDs.
package tank_pkg;

    localparam int COORD_W = 6;
    localparam int MAP_LAT = 1;

    typedef enum logic [1:0] {
        REQ_TANK1  = 2'd0,
        REQ_TANK2  = 2'd1,
        REQ_SHELL1 = 2'd2,
        REQ_SHELL2 = 2'd3
    } req_id_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin picker: first request at or after ptr wins, wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] cand_s;

    // scan candidates starting at ptr; wrap is explicit so N need not be a power of two
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        sum_s  = '0;
        cand_s = '0;
        for (int off = 0; off < N; off++) begin
            sum_s = {1'b0, ptr} + (PW + 1)'(off);
            if (sum_s >= (PW + 1)'(N)) begin
                sum_s = sum_s - (PW + 1)'(N);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[PW-1:0];
            if (!any && req[cand_s]) begin
                any         = 1'b1;
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the map wall-lookup port between VGA scan-out (absolute priority) and
// round-robin game-logic requesters; tags each lookup so its result returns to its owner.
module map_port_arbiter
    import tank_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int COORD_W    = tank_pkg::COORD_W,
    parameter int LAT        = tank_pkg::MAP_LAT,
    parameter int STARVE_LIM = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vga_busy,
    input  logic [COORD_W-1:0]       i_vga_x,
    input  logic [COORD_W-1:0]       i_vga_y,
    output logic                     o_vga_is_wall,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*COORD_W-1:0] i_req_x,
    input  logic [N_REQ*COORD_W-1:0] i_req_y,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_rvalid,
    output logic                     o_rdata,
    output logic [COORD_W-1:0]       o_map_x,
    output logic [COORD_W-1:0]       o_map_y,
    input  logic                     i_map_is_wall,
    output logic                     o_starve
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIM);

    logic [N_REQ-1:0]   req_ok_s;
    logic [N_REQ-1:0]   gnt_s;
    logic [PW-1:0]      win_s;
    logic               any_s;
    logic [PW-1:0]      ptr_r;
    logic [COORD_W-1:0] map_x_s;
    logic [COORD_W-1:0] map_y_s;
    logic [LAT-1:0]     tag_vld_r;
    logic [N_REQ-1:0]   tag_id_r [LAT];
    logic [7:0]         wait_r [N_REQ];
    logic [7:0]         wait_nxt_s [N_REQ];
    logic               starve_hit_s;

    // VGA owns the port outright while drawing, so requests are simply masked
    assign req_ok_s      = i_vga_busy ? '0 : i_req;
    assign o_gnt         = gnt_s;
    assign o_vga_is_wall = i_map_is_wall;
    assign o_map_x       = map_x_s;
    assign o_map_y       = map_y_s;

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr (
        .req (req_ok_s),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (win_s),
        .any (any_s)
    );

    // map address: granted requester's coordinates, otherwise the VGA scan position
    always_comb begin
        map_x_s = i_vga_x;
        map_y_s = i_vga_y;
        if (any_s) begin
            map_x_s = i_req_x[int'(win_s)*COORD_W +: COORD_W];
            map_y_s = i_req_y[int'(win_s)*COORD_W +: COORD_W];
        end else begin
            map_x_s = i_vga_x;
            map_y_s = i_vga_y;
        end
    end

    // round-robin pointer moves just past the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (any_s) begin
            ptr_r <= (int'(win_s) == N_REQ - 1) ? '0 : win_s + PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // tag pipeline tracks which requester owns each lookup in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_vld_r[0] <= any_s;
            tag_id_r[0]  <= gnt_s;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    // capture map data as the owning tag reaches the last stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rvalid <= '0;
            o_rdata  <= 1'b0;
        end else begin
            o_rvalid <= tag_vld_r[LAT-1] ? tag_id_r[LAT-1] : '0;
            o_rdata  <= tag_vld_r[LAT-1] ? i_map_is_wall : o_rdata;
        end
    end

    // next wait counts; starvation is judged on the value the counter is about to take
    always_comb begin
        starve_hit_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            wait_nxt_s[k] = 8'd0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (i_req[k] && !gnt_s[k]) begin
                wait_nxt_s[k] = sat_inc8(wait_r[k]);
            end else begin
                wait_nxt_s[k] = 8'd0;
            end
            if (wait_nxt_s[k] >= STARVE_LIM8) begin
                starve_hit_s = 1'b1;
            end else begin
                starve_hit_s = starve_hit_s;
            end
        end
    end

    // wait counters and sticky starvation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                wait_r[k] <= 8'd0;
            end
            o_starve <= 1'b0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                wait_r[k] <= wait_nxt_s[k];
            end
            o_starve <= o_starve | starve_hit_s;
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed scoreboard bench for map_port_arbiter (LAT=1, N_REQ=4, STARVE_LIM=4).
module tb_map_port_arbiter;
    import tank_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 6;
    localparam int LAT  = 1;
    localparam int SLIM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_busy;
    logic [CW-1:0] vga_x, vga_y;
    logic          vga_is_wall;
    logic [N-1:0]  req;
    logic [N*CW-1:0] req_x, req_y;
    logic [N-1:0]  gnt, rvalid;
    logic          rdata;
    logic [CW-1:0] map_x, map_y;
    logic          map_is_wall;
    logic          starve;

    typedef struct {
        int         due;
        logic [3:0] id;
        logic       data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    int   m_wait [N];
    logic m_starve = 1'b0;

    map_port_arbiter #(
        .N_REQ(N), .COORD_W(CW), .LAT(LAT), .STARVE_LIM(SLIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_vga_busy(vga_busy), .i_vga_x(vga_x), .i_vga_y(vga_y), .o_vga_is_wall(vga_is_wall),
        .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_map_x(map_x), .o_map_y(map_y), .i_map_is_wall(map_is_wall),
        .o_starve(starve)
    );

    always #5 clk = ~clk;

    function automatic logic wall_fn(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return ^{x[2:0], y[1:0]};
    endfunction

    // map store model: one-cycle registered read of whatever address is presented
    always @(posedge clk) map_is_wall <= wall_fn(map_x, map_y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input int k, input logic [CW-1:0] x, input logic [CW-1:0] y);
        req_x[k*CW +: CW] = x;
        req_y[k*CW +: CW] = y;
    endtask

    // one clock cycle: inputs already driven just after the rising edge
    task automatic tick(input string tag);
        logic [3:0]    eg;
        logic [CW-1:0] ex, ey;
        logic [3:0]    erv;
        int            w, c;
        eg = '0; ex = vga_x; ey = vga_y; w = -1;
        if (!vga_busy) begin
            for (int o = 0; o < N; o++) begin
                c = (m_ptr + o) % N;
                if (w < 0 && req[c]) w = c;
            end
        end
        if (w >= 0) begin
            eg[w] = 1'b1;
            ex = req_x[w*CW +: CW];
            ey = req_y[w*CW +: CW];
        end
        @(negedge clk);
        chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ":map_x"}, 32'(map_x), 32'(ex));
        chk({tag, ":map_y"}, 32'(map_y), 32'(ey));
        chk({tag, ":vga_wall"}, 32'(vga_is_wall), 32'(map_is_wall));
        if (w >= 0) begin
            sb.push_back('{cyc + 2, eg, wall_fn(ex, ey)});
            m_ptr = (w + 1) % N;
        end
        for (int k = 0; k < N; k++) begin
            if (req[k] && !eg[k]) m_wait[k] = (m_wait[k] >= 255) ? 255 : m_wait[k] + 1;
            else m_wait[k] = 0;
            if (m_wait[k] >= SLIM) m_starve = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        erv = (sb.size() > 0 && sb[0].due == cyc) ? sb[0].id : 4'd0;
        chk({tag, ":rvalid"}, 32'(rvalid), 32'(erv));
        if (erv != 4'd0) begin
            chk({tag, ":rdata"}, 32'(rdata), 32'(sb[0].data));
            void'(sb.pop_front());
        end
        chk({tag, ":starve"}, 32'(starve), 32'(m_starve));
    endtask

    // async reset asserted mid-cycle, discarding anything in flight
    task automatic apply_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        chk({tag, ":rst_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, ":rst_rdata"}, 32'(rdata), 32'd0);
        chk({tag, ":rst_starve"}, 32'(starve), 32'd0);
        sb.delete();
        m_ptr = 0;
        m_starve = 1'b0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; vga_busy = 1'b0; vga_x = '0; vga_y = '0;
        req = '0; req_x = '0; req_y = '0;
        for (int k = 0; k < N; k++) m_wait[k] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("init:rvalid", 32'(rvalid), 32'd0);
        chk("init:rdata", 32'(rdata), 32'd0);
        chk("init:starve", 32'(starve), 32'd0);
        chk("init:gnt", 32'(gnt), 32'd0);
        rst_n = 1'b1;
        tick("idle");

        // single requester, wall at (5,9)
        req = 4'b0001; set_xy(REQ_TANK1, 6'd5, 6'd9);
        tick("single");
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick("single_drain");

        // all four requesting: strict rotation
        set_xy(0, 6'd1, 6'd2); set_xy(1, 6'd7, 6'd3);
        set_xy(2, 6'd12, 6'd33); set_xy(3, 6'd63, 6'd62);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) tick("rr");
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick("rr_drain");

        // VGA priority: requests wait, VGA addresses reach the map
        vga_busy = 1'b1; req = 4'b0110;
        set_xy(1, 6'd20, 6'd21); set_xy(2, 6'd40, 6'd41);
        for (int i = 0; i < 10; i++) begin
            vga_x = 6'(i * 3); vga_y = 6'(i * 5 + 1);
            tick("vga");
        end
        vga_busy = 1'b0;
        tick("vga_release");
        req = 4'b0100;
        tick("vga_second");
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick("vga_drain");

        // reset with a lookup in flight; no stray result afterwards
        req = 4'b0001; set_xy(0, 6'd5, 6'd9);
        tick("pre_reset");
        req = 4'b0000;
        apply_reset("midlookup");
        for (int i = 0; i < 3; i++) tick("post_reset");

        // VGA rises while a lookup is in flight
        req = 4'b0010; set_xy(1, 6'd13, 6'd6);
        tick("vga_edge_gnt");
        req = 4'b0000; vga_busy = 1'b1; vga_x = 6'd2; vga_y = 6'd2;
        tick("vga_edge_t1");
        tick("vga_edge_t2");
        vga_busy = 1'b0;
        tick("vga_edge_t3");

        // starvation: blocked for exactly the limit, then sticky
        apply_reset("pre_starve");
        vga_busy = 1'b1; req = 4'b0001; set_xy(0, 6'd30, 6'd31);
        for (int i = 0; i < 4; i++) tick("starve_wait");
        vga_busy = 1'b0;
        tick("starve_gnt");
        req = 4'b0000;
        for (int i = 0; i < 3; i++) tick("starve_hold");
        apply_reset("final");
        tick("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
